// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer for the single-cycle core.
// Turns the host req/done handshake into a bounded program run: the core is
// held in reset while the host owns data memory, then released until it
// reaches HALT_PC or the cycle limit. Data-memory ownership is muxed here.
module run_ctrl #(
  parameter int D       = 12,
  parameter int AW      = 8,
  parameter int HALT_PC = 128,
  parameter int CW      = 16,
  parameter int CLR_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic          timeout,
  output logic          busy,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_rst,
  output logic          core_en,
  output logic          host_gnt,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdat,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [7:0]    core_wdat,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdat,
  output logic [CW-1:0] cycle_cnt
);

  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYC - 1);
  localparam logic [D-1:0]     HALT_VAL = D'(HALT_PC);
  // Value of cycle_cnt during the final permitted RUN cycle.
  localparam logic [CW-1:0]    CNT_LAST = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0]    CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             req_q;
  logic [CLR_W-1:0] clr_cnt;
  logic             start;
  logic             halt_hit;
  logic             limit_hit;

  logic done_next;
  logic busy_next;
  logic core_rst_next;
  logic core_en_next;
  logic host_gnt_next;

  // req_q resets high so a req level held through reset is not a rising edge.
  assign start     = req & ~req_q;
  assign halt_hit  = (prog_ctr == HALT_VAL);
  assign limit_hit = (cycle_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; in RUN, halt beats timeout beats abort.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_CLR;
      ST_CLR:  if (clr_cnt == '0) state_next = ST_RUN;
      ST_RUN: begin
        if (halt_hit)       state_next = ST_FIN;
        else if (limit_hit) state_next = ST_FIN;
        else if (!req)      state_next = ST_IDLE;
      end
      ST_FIN:  if (!req) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode of the current state; registered below, so outputs lag one edge.
  always_comb begin
    done_next     = (state_reg == ST_FIN);
    busy_next     = (state_reg == ST_CLR) || (state_reg == ST_RUN);
    core_rst_next = (state_reg == ST_IDLE) || (state_reg == ST_CLR);
    core_en_next  = (state_reg == ST_RUN);
    host_gnt_next = (state_reg == ST_IDLE) || (state_reg == ST_FIN);
  end

  // Registered state-derived outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done     <= 1'b0;
      busy     <= 1'b0;
      core_rst <= 1'b1;
      core_en  <= 1'b0;
      host_gnt <= 1'b1;
    end else begin
      done     <= done_next;
      busy     <= busy_next;
      core_rst <= core_rst_next;
      core_en  <= core_en_next;
      host_gnt <= host_gnt_next;
    end
  end

  // Request edge detector, CLR hold counter, run-cycle counter and timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q     <= 1'b1;
      clr_cnt   <= '0;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      req_q <= req;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            clr_cnt   <= CLR_LOAD;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
          end
        end
        ST_CLR: begin
          if (clr_cnt != '0) clr_cnt <= clr_cnt - 1'b1;
        end
        ST_RUN: begin
          if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
          if (!halt_hit && limit_hit) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Data-memory port mux; a core write only lands while the core is enabled.
  always_comb begin
    mem_addr = host_gnt ? host_addr : core_addr;
    mem_wdat = host_gnt ? host_wdat : core_wdat;
    mem_we   = host_gnt ? host_we   : (core_we & core_en);
  end

endmodule
